// File: rtl/board_tile_writer.sv
// rtl/board_tile_writer.sv - turns board draw/clear commands into sequential tile-RAM writes
// Optional: define BOARD_TILE_WRITER_CURSOR_EN to make mark 3 draw a cursor border.
module board_tile_writer #(
  parameter int RAM_DATA_WIDTH = 7,
  parameter int RAM_ADDR_WIDTH = 9,
  parameter int SCREEN_COLS    = 20,
  parameter int SCREEN_ROWS    = 15,
  parameter int CELL_TILES     = 4,
  parameter int ORIGIN_ROW     = 1,
  parameter int ORIGIN_COL     = 4,
  parameter int BG_TILE        = 0,
  parameter int EMPTY_BASE     = 48,
  parameter int X_BASE         = 16,
  parameter int O_BASE         = 32,
  parameter int CURSOR_BASE    = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_clear_i,
  input  logic [1:0]                req_row_i,
  input  logic [1:0]                req_col_i,
  input  logic [1:0]                req_mark_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [RAM_DATA_WIDTH-1:0] data_o,
  output logic [RAM_ADDR_WIDTH-1:0] write_addr_o,
  output logic                      we_o
);
  localparam int SCREEN_TILES = SCREEN_COLS * SCREEN_ROWS;
  localparam int AW = RAM_ADDR_WIDTH + 2;
  localparam int CW = ($clog2(SCREEN_TILES + 1) > 5) ? $clog2(SCREEN_TILES + 1) : 5;
  localparam int DW = RAM_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FINISH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, step;
  logic [1:0]    row_q, col_q, mark_q;
  logic          accept, legal, mark_ok;
  logic          we_d, err_d;
  logic [DW-1:0] data_d, base, draw_data;
  logic [RAM_ADDR_WIDTH-1:0] addr_d;
  logic [AW-1:0] tile_row, tile_col, draw_addr;

  assign accept = req_valid_i && req_ready_o;

`ifdef BOARD_TILE_WRITER_CURSOR_EN
  assign mark_ok = 1'b1;
  // Cursor only paints the cell border: jump over the two interior tiles of rows 1 and 2.
  assign step = (mark_q == 2'd3 && (cnt_q[3:0] == 4'd4 || cnt_q[3:0] == 4'd8)) ? CW'(3) : CW'(1);
`else
  assign mark_ok = (req_mark_i != 2'd3);
  assign step    = CW'(1);
`endif

  assign legal = (req_row_i != 2'd3) && (req_col_i != 2'd3) && mark_ok;

  // cnt_q[3:2] is the tile row (ty) inside the cell, cnt_q[1:0] the tile column (tx).
  assign tile_row  = AW'(ORIGIN_ROW) + AW'(row_q) * AW'(CELL_TILES) + AW'(cnt_q[3:2]);
  assign tile_col  = AW'(ORIGIN_COL) + AW'(col_q) * AW'(CELL_TILES) + AW'(cnt_q[1:0]);
  assign draw_addr = tile_row * AW'(SCREEN_COLS) + tile_col;

  always_comb begin
    base = DW'(EMPTY_BASE);
    case (mark_q)
      2'd1:    base = DW'(X_BASE);
      2'd2:    base = DW'(O_BASE);
      2'd3:    base = DW'(CURSOR_BASE);
      default: base = DW'(EMPTY_BASE);
    endcase
  end

  assign draw_data = base + DW'(cnt_q[3:2]) * DW'(CELL_TILES) + DW'(cnt_q[1:0]);

  // Counter runs one past the last tile so the write pipeline drains before FINISH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    data_d  = data_o;
    addr_d  = write_addr_o;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (req_clear_i) begin
            state_d = CLEAR;
          end else if (legal) begin
            state_d = DRAW;
          end else begin
            state_d = FINISH;
            err_d   = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (cnt_q == CW'(SCREEN_TILES)) begin
          state_d = FINISH;
        end else begin
          we_d   = 1'b1;
          addr_d = RAM_ADDR_WIDTH'(cnt_q);
          data_d = DW'(BG_TILE);
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DRAW: begin
        if (cnt_q[4]) begin
          state_d = FINISH;
        end else begin
          we_d   = 1'b1;
          addr_d = draw_addr[RAM_ADDR_WIDTH-1:0];
          data_d = draw_data;
          cnt_d  = cnt_q + step;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      mark_q       <= '0;
      req_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      we_o         <= 1'b0;
      data_o       <= '0;
      write_addr_o <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      if (accept) begin
        row_q  <= req_row_i;
        col_q  <= req_col_i;
        mark_q <= req_mark_i;
      end
      req_ready_o  <= (state_d == IDLE);
      busy_o       <= (state_d != IDLE);
      done_o       <= (state_d == FINISH);
      err_o        <= err_d;
      we_o         <= we_d;
      data_o       <= data_d;
      write_addr_o <= addr_d;
    end
  end
endmodule
